// File: rtl/airlock_pkg.sv
// Shared state codes and parameter checks for the airlock sequencer.
package airlock_pkg;

  localparam logic [2:0] S_LOW   = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  function automatic bit ticks_ok(
    input longint ticks,
    input int     w
  );
    return (ticks >= 1) &&
           (ticks <= (longint'(1) << w) - 1);
  endfunction

endpackage

// File: rtl/airlock_tick_counter.sv
// Loadable down-counter that saturates at zero.
module tick_counter
  import airlock_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             zero_next
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign zero_next = en && !clr && !load &&
                     (count_q == CNT_W'(1));

endmodule

// File: rtl/airlock_seq.sv
// Airlock interlock FSM: door ownership, fill/drain/wait
// countdowns, docking state and latched pressure fault.
module airlock_seq
  import airlock_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int FILL_TICKS  = 7,
  parameter int DRAIN_TICKS = 8,
  parameter int WAIT_TICKS  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             fill_hold,
  input  logic             drain_hold,
  input  logic             inner_req,
  input  logic             outer_req,
  input  logic             arrive,
  input  logic             leave,
  input  logic             pressure_ok,
  input  logic             fault_ack,
  output logic             inner_open,
  output logic             outer_open,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] remaining,
  output logic             docked,
  output logic             done,
  output logic             fault
);

  if (!ticks_ok(FILL_TICKS, CNT_W) ||
      !ticks_ok(DRAIN_TICKS, CNT_W) ||
      !ticks_ok(WAIT_TICKS, CNT_W)) begin : g_bad_ticks
    $error("airlock_seq: tick parameter out of range");
  end

  logic [2:0] st_q, st_d;
  logic inner_q, inner_d;
  logic outer_q, outer_d;
  logic docked_q, docked_d;
  logic pending_q, pending_d;
  logic done_q, done_d;
  logic fault_q, fault_d;

  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic             en;
  logic             clr;
  logic             zero_next;

  tick_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (ld),
    .load_val  (ld_val),
    .en        (en),
    .clr       (clr),
    .count     (remaining),
    .zero_next (zero_next)
  );

  always_comb begin
    st_d      = st_q;
    inner_d   = 1'b0;
    outer_d   = 1'b0;
    docked_d  = docked_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    ld        = 1'b0;
    ld_val    = '0;
    en        = 1'b0;
    clr       = 1'b0;
    unique case (st_q)
      S_LOW: begin
        inner_d = inner_req;
        if (fill_hold && !inner_req && !inner_q) begin
          st_d   = S_FILL;
          ld     = 1'b1;
          ld_val = CNT_W'(FILL_TICKS);
        end
      end
      S_FILL: begin
        if (!pressure_ok) begin
          st_d = S_FAULT;
          clr  = 1'b1;
        end else if (tick && fill_hold) begin
          en = 1'b1;
          if (zero_next) begin
            st_d   = S_HIGH;
            done_d = 1'b1;
          end
        end
      end
      S_HIGH: begin
        outer_d = outer_req;
        // door must read closed a full cycle before leaving
        if (!outer_req && !outer_q) begin
          if (drain_hold) begin
            st_d   = S_DRAIN;
            ld     = 1'b1;
            ld_val = CNT_W'(DRAIN_TICKS);
          end else if (arrive && !leave && !docked_q) begin
            st_d      = S_WAIT;
            ld        = 1'b1;
            ld_val    = CNT_W'(WAIT_TICKS);
            pending_d = 1'b1;
          end else if (leave && !arrive && docked_q) begin
            st_d      = S_WAIT;
            ld        = 1'b1;
            ld_val    = CNT_W'(WAIT_TICKS);
            pending_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (!pressure_ok) begin
          st_d = S_FAULT;
          clr  = 1'b1;
        end else if (tick && drain_hold) begin
          en = 1'b1;
          if (zero_next) begin
            st_d   = S_LOW;
            done_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (tick) begin
          en = 1'b1;
          if (zero_next) begin
            st_d     = S_HIGH;
            docked_d = pending_q;
            done_d   = 1'b1;
          end
        end
      end
      S_FAULT: begin
        clr = 1'b1;
        if (fault_ack && pressure_ok) begin
          st_d = S_LOW;
        end
      end
      default: begin
        st_d = S_LOW;
        clr  = 1'b1;
      end
    endcase
    fault_d = (st_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= S_LOW;
      inner_q   <= 1'b0;
      outer_q   <= 1'b0;
      docked_q  <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      inner_q   <= inner_d;
      outer_q   <= outer_d;
      docked_q  <= docked_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign state      = st_q;
  assign inner_open = inner_q;
  assign outer_open = outer_q;
  assign docked     = docked_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule
